// File: rtl/base_addr_fetch.sv
// Reads NUM_WORDS consecutive base-address words from a BRAM controller port into
// a register bank; supports multi-cycle read latency, auto-start and re-fetch.
module base_addr_fetch #(
  parameter logic [31:0] START_ADDR  = 32'h4580_0000,
  parameter int          NUM_WORDS   = 4,
  parameter logic [31:0] ADDR_STRIDE = 32'd4,
  parameter int          RD_LATENCY  = 2,
  parameter bit          AUTO_START  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    ram_clk,
  output logic                    ram_rst,
  output logic [31:0]             ram_addr,
  output logic                    ram_en,
  input  logic [31:0]             ram_rd_data,
  output logic [3:0]              ram_we,
  output logic [31:0]             ram_wd_data,
  output logic [32*NUM_WORDS-1:0] words_out,
  output logic                    busy,
  output logic                    done,
  output logic                    done_pulse
);

  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int CW = $clog2(NUM_WORDS + 1);

  if (NUM_WORDS < 1 || RD_LATENCY < 1) begin : g_param_check
    $error("base_addr_fetch: NUM_WORDS and RD_LATENCY must both be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t              state;
  logic                auto_pending;
  logic [CW-1:0]       issue_idx;
  logic [CW-1:0]       cap_cnt;
  // Stage 0 mirrors the issue register; stage RD_LATENCY lines up with valid read data.
  logic [RD_LATENCY:0] pipe_vld;
  logic [IW-1:0]       pipe_idx [RD_LATENCY+1];

  assign ram_clk     = clk;
  assign ram_rst     = 1'b0;
  assign ram_we      = 4'b0;
  assign ram_wd_data = 32'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      auto_pending <= AUTO_START;
      issue_idx    <= '0;
      cap_cnt      <= '0;
      ram_addr     <= '0;
      ram_en       <= 1'b0;
      words_out    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      done_pulse   <= 1'b0;
      pipe_vld     <= '0;
      for (int j = 0; j <= RD_LATENCY; j++) pipe_idx[j] <= '0;
    end else begin
      auto_pending <= 1'b0;
      done_pulse   <= 1'b0;
      ram_en       <= 1'b0;
      ram_addr     <= '0;
      pipe_vld     <= {pipe_vld[RD_LATENCY-1:0], 1'b0};
      for (int j = 1; j <= RD_LATENCY; j++) pipe_idx[j] <= pipe_idx[j-1];

      if (pipe_vld[RD_LATENCY]) begin
        words_out[32*int'(pipe_idx[RD_LATENCY]) +: 32] <= ram_rd_data;
        cap_cnt <= cap_cnt + CW'(1);
      end

      case (state)
        IDLE, DONE: begin
          if (start || auto_pending) begin
            busy        <= 1'b1;
            done        <= 1'b0;
            ram_en      <= 1'b1;
            ram_addr    <= START_ADDR;
            pipe_vld[0] <= 1'b1;
            pipe_idx[0] <= '0;
            issue_idx   <= CW'(1);
            cap_cnt     <= '0;
            state       <= (NUM_WORDS == 1) ? DRAIN : ISSUE;
          end
        end
        ISSUE: begin
          ram_en      <= 1'b1;
          ram_addr    <= START_ADDR + ADDR_STRIDE * 32'(issue_idx);
          pipe_vld[0] <= 1'b1;
          pipe_idx[0] <= IW'(issue_idx);
          issue_idx   <= issue_idx + CW'(1);
          if (issue_idx == CW'(NUM_WORDS - 1)) state <= DRAIN;
        end
        DRAIN: begin
          if (pipe_vld[RD_LATENCY] && cap_cnt == CW'(NUM_WORDS - 1)) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            done_pulse <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/base_addr_fetch.md
Name: base_addr_fetch

Overview:
- Parametrised successor to the single-word base-address reader.
- Fetches NUM_WORDS consecutive 32-bit configuration/base-address words from a BRAM controller port, starting at START_ADDR with a fixed byte stride, and holds them in output registers.
- Handles configurable BRAM read latency, optional auto-start after reset, and re-fetch on request.
- Sits between the AXI BRAM controller port and the m01 signal/DMA control logic, which consumes the word bank and the done flag.

Parameters:
- START_ADDR, 32'h4580_0000, byte address of word 0.
- NUM_WORDS, 4, number of words fetched (1..16).
- ADDR_STRIDE, 4, byte increment between words.
- RD_LATENCY, 2, cycles from address/enable to valid ram_rd_data (1..4).
- AUTO_START, 1, 1 = start one fetch automatically after reset; 0 = wait for start.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- start  in  1  fetch request, sampled on rising clk edge
- ram_clk  out  1  BRAM clock, = clk
- ram_rst  out  1  BRAM reset, constant 0
- ram_addr  out  32  BRAM byte address, registered
- ram_en  out  1  BRAM enable, registered
- ram_rd_data  in  32  BRAM read data
- ram_we  out  4  constant 4'b0 (write unused)
- ram_wd_data  out  32  constant 0
- words_out  out  32*NUM_WORDS  word i at bits [32i+31:32i]
- busy  out  1  fetch in progress
- done  out  1  level: word bank valid and complete
- done_pulse  out  1  one-cycle pulse when done rises

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk.
- Reset values: ram_addr=0, ram_en=0, words_out=0, busy=0, done=0, done_pulse=0, state=IDLE, issue/capture counters=0, latency pipeline cleared.
- States:
  - IDLE: waits for a trigger, then goes to ISSUE.
  - ISSUE: issues NUM_WORDS reads.
  - DRAIN: waits for outstanding captures, then goes to DONE.
  - DONE: holds results.
- Trigger: start=1 sampled in IDLE or DONE. With AUTO_START=1, the first rising edge after rst_n deasserts acts as a trigger regardless of start.
- At the trigger edge (E0):
  - busy goes to 1.
  - done goes to 0.
  - The issue index is cleared.
  - Issue cycle i (i=0..NUM_WORDS-1) is the cycle following edge E0+i, with ram_en=1 and ram_addr = START_ADDR + i*ADDR_STRIDE (32-bit modulo wrap).
- Outside ISSUE cycles: ram_en=0 and ram_addr=0.
- Latency pipeline: a RD_LATENCY-deep shift of {valid, index} tracks each issue. Data for issue i is captured from ram_rd_data into word i at edge E0+i+RD_LATENCY+1.
- Issue-to-drain transition: after the last issue, the FSM moves to DRAIN. DRAIN exits when capture count == NUM_WORDS.
- Completion: at edge E0+NUM_WORDS+RD_LATENCY, done=1, busy=0, and done_pulse=1 for exactly one cycle. State is DONE.
- words_out during a re-fetch: each word keeps its previous value until it is overwritten by its own capture. Consumers must qualify with done.
- start while busy (ISSUE/DRAIN): ignored, no queueing.
- start held high continuously: re-fetches back-to-back. Each completion gives done high for one cycle, then a new trigger.
- Reset mid-fetch: all state returns to reset values immediately and in-flight captures are discarded. With AUTO_START=1, a fresh fetch begins after release.
- Word-to-index mapping: ram_rd_data is captured only on pipeline-valid cycles, so data on other cycles is ignored.
- Elaboration checks: NUM_WORDS<1 or RD_LATENCY<1 is an elaboration error.

Test Plan:
- Auto-start, defaults (BRAM model: word at A = A^32'hA5A5_0000, latency 2):
  - Release reset → ram_addr sequence 4580_0000, 4580_0004, 4580_0008, 4580_000C with ram_en=1 for 4 cycles, then 0.
  - done rises 6 edges after the first post-reset edge, with a single-cycle done_pulse.
  - words_out[31:0]=E025_0000, words_out[127:96]=E025_000C.
- AUTO_START=0:
  - No start pulse → ram_en stays 0 and done stays 0 for 50 cycles.
  - A 1-cycle start pulse → same fetch as the auto-start case, completing 6 edges after start.
- Re-fetch:
  - After done, change the BRAM contents and pulse start → done drops the next cycle.
  - Words update in order; done=1 with new values after 6 edges.
  - Start pulses issued during busy produce no extra fetch.
- Reset mid-operation: assert rst_n=0 during the 2nd issue cycle → outputs immediately reach reset values; after release, a full clean fetch completes with correct data.
- Latency/width sweep:
  - RD_LATENCY=1 with NUM_WORDS=1, and RD_LATENCY=4 with NUM_WORDS=16, ADDR_STRIDE=8 → done after NUM_WORDS+RD_LATENCY edges.
  - Last address is START_ADDR+0x78.
  - All words are correct with no index skew.
- Address wrap: START_ADDR=32'hFFFF_FFF8, NUM_WORDS=4 → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
